updown_counter_mod: RTL and testbench

Parametrised up/down counter, next generation of the fixed 8-bit up/down counter. Adds:
- generic WIDTH
- runtime modulus (max_val)
- wrap or saturate mode
- synchronous parallel load
- terminal-count flag and one-cycle carry/borrow pulses
- saturating 8-bit overflow-event counter

Used as timebase/event counter in lab datapaths. With max_val = all-ones and sat=0 it behaves exactly as the legacy 8-bit up/down counter.

---
 rtl/updown_counter_mod.sv | 113 +++++++++++
 tb/tb_updown_counter_mod.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// ---------------------------------------------------------------------------
// updown_counter_mod
//   Parametrised up/down counter with runtime modulus, wrap/saturate mode,
//   synchronous parallel load, terminal-count flag, one-cycle carry/borrow
//   pulses and a saturating overflow-event counter.
//   With i_max_val = all-ones and i_sat = 0 it matches the legacy fixed
//   8-bit up/down counter.
//
// Ports
//   i_clk      rising-edge clock
//   i_rst      synchronous reset, active-low
//   i_en       count enable
//   i_up       direction: 1 = up, 0 = down
//   i_ld       synchronous load strobe (beats i_en)
//   i_din      load value, clamped to i_max_val
//   i_max_val  inclusive upper limit, may change at runtime
//   i_sat      1 = saturate at limits, 0 = wrap
//   o_dout     registered count
//   o_tc       terminal count (combinational from o_dout/i_up/i_max_val)
//   o_carry    registered one-cycle pulse on up-wrap
//   o_borrow   registered one-cycle pulse on down-wrap
//   o_ovf_cnt  saturating count of carry/borrow events
// ---------------------------------------------------------------------------
module updown_counter_mod #(
    parameter int WIDTH = 8,
    parameter int OVF_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_din,
    input  logic [WIDTH-1:0] i_max_val,
    input  logic             i_sat,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_tc,
    output logic             o_carry,
    output logic             o_borrow,
    output logic [OVF_W-1:0] o_ovf_cnt
);

    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [OVF_W-1:0] OVF_MAX = '1;

    logic [WIDTH-1:0] r_dout;
    logic             r_carry;
    logic             r_borrow;
    logic [OVF_W-1:0] r_ovf_cnt;

    logic [WIDTH-1:0] w_dout_nxt;
    logic             w_carry_nxt;
    logic             w_borrow_nxt;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_over;

    assign w_at_max  = (r_dout == i_max_val);
    assign w_at_zero = (r_dout == ZERO);
    // Count can sit above the limit after i_max_val is lowered at runtime.
    assign w_over    = (r_dout > i_max_val);

    always_comb begin
        w_dout_nxt   = r_dout;
        w_carry_nxt  = 1'b0;
        w_borrow_nxt = 1'b0;
        if (i_ld) begin
            w_dout_nxt = (i_din > i_max_val) ? i_max_val : i_din;
        end else if (i_en) begin
            if (w_over) begin
                // Pull back into range without signalling a wrap.
                w_dout_nxt = i_max_val;
            end else if (i_up) begin
                if (!w_at_max) begin
                    w_dout_nxt = r_dout + ONE;
                end else if (!i_sat) begin
                    w_dout_nxt  = ZERO;
                    w_carry_nxt = 1'b1;
                end
            end else begin
                if (!w_at_zero) begin
                    w_dout_nxt = r_dout - ONE;
                end else if (!i_sat) begin
                    w_dout_nxt   = i_max_val;
                    w_borrow_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_dout    <= '0;
            r_carry   <= 1'b0;
            r_borrow  <= 1'b0;
            r_ovf_cnt <= '0;
        end else begin
            r_dout   <= w_dout_nxt;
            r_carry  <= w_carry_nxt;
            r_borrow <= w_borrow_nxt;
            if ((w_carry_nxt || w_borrow_nxt) && (r_ovf_cnt != OVF_MAX))
                r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
        end
    end

    assign o_dout    = r_dout;
    assign o_carry   = r_carry;
    assign o_borrow  = r_borrow;
    assign o_ovf_cnt = r_ovf_cnt;
    assign o_tc      = i_up ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_updown_counter_mod.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_mod
//   Directed bench for updown_counter_mod (WIDTH=8, OVF_W=8): a table of
//   single-cycle vectors with hand-computed results, followed by the
//   long-running sequences (wraps over hundreds of cycles, saturation,
//   reset mid-count, overflow-counter saturation).
// ---------------------------------------------------------------------------
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       rst, en, up, ld, sat;
    logic [7:0] din, max_val;
    logic [7:0] dout, ovf_cnt;
    logic       tc, carry, borrow;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(8), .OVF_W(8)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en     (en),
        .i_up     (up),
        .i_ld     (ld),
        .i_din    (din),
        .i_max_val(max_val),
        .i_sat    (sat),
        .o_dout   (dout),
        .o_tc     (tc),
        .o_carry  (carry),
        .o_borrow (borrow),
        .o_ovf_cnt(ovf_cnt)
    );

    typedef struct {
        logic       rst, en, up, ld, sat;
        logic [7:0] din, max_val;
        logic [7:0] e_dout;
        logic       e_tc, e_carry, e_borrow;
        logic [7:0] e_ovf;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic r, e, u, l, s, input logic [7:0] d, m,
                        input logic [7:0] ed, input logic etc, ec, eb,
                        input logic [7:0] eo);
        vec_t v;
        v.rst = r; v.en = e; v.up = u; v.ld = l; v.sat = s;
        v.din = d; v.max_val = m;
        v.e_dout = ed; v.e_tc = etc; v.e_carry = ec; v.e_borrow = eb;
        v.e_ovf = eo;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next
    // falling edge, after the rising edge has taken effect.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; ld = 1'b0;
        tick(); tick();
        rst = 1'b1;
    endtask

    int cnt_c, cnt_b;

    // Run n enabled cycles, counting pulses seen.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (carry)  cnt_c++;
            if (borrow) cnt_b++;
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b1; ld = 1'b0; sat = 1'b0;
        din = '0; max_val = 8'd10;

        //    rst en up ld sat din   max   dout tc c  b  ovf
        addv(0, 0, 1, 0, 0, 8'd0,   8'd10, 8'd0,  0, 0, 0, 8'd0);
        addv(0, 1, 1, 0, 0, 8'd0,   8'd10, 8'd0,  0, 0, 0, 8'd0);
        addv(1, 0, 1, 0, 0, 8'd0,   8'd10, 8'd0,  0, 0, 0, 8'd0);
        addv(1, 1, 1, 0, 0, 8'd0,   8'd3,  8'd1,  0, 0, 0, 8'd0);
        addv(1, 1, 1, 0, 0, 8'd0,   8'd3,  8'd2,  0, 0, 0, 8'd0);
        addv(1, 1, 1, 0, 0, 8'd0,   8'd3,  8'd3,  1, 0, 0, 8'd0);
        addv(1, 1, 1, 0, 0, 8'd0,   8'd3,  8'd0,  0, 1, 0, 8'd1);
        addv(1, 1, 0, 0, 0, 8'd0,   8'd3,  8'd3,  0, 0, 1, 8'd2);
        addv(1, 1, 0, 0, 0, 8'd0,   8'd3,  8'd2,  0, 0, 0, 8'd2);
        addv(1, 1, 0, 1, 0, 8'd200, 8'd99, 8'd99, 0, 0, 0, 8'd2);
        addv(1, 1, 0, 1, 0, 8'd7,   8'd99, 8'd7,  0, 0, 0, 8'd2);
        addv(1, 1, 1, 0, 0, 8'd0,   8'd5,  8'd5,  1, 0, 0, 8'd2);
        addv(1, 1, 1, 0, 1, 8'd0,   8'd5,  8'd5,  1, 0, 0, 8'd2);
        addv(1, 1, 0, 0, 1, 8'd0,   8'd5,  8'd4,  0, 0, 0, 8'd2);
        addv(1, 1, 0, 1, 1, 8'd0,   8'd5,  8'd0,  1, 0, 0, 8'd2);
        addv(1, 1, 0, 0, 1, 8'd0,   8'd5,  8'd0,  1, 0, 0, 8'd2);
        addv(1, 1, 0, 0, 0, 8'd0,   8'd5,  8'd5,  0, 0, 1, 8'd3);
        addv(1, 0, 1, 0, 0, 8'd0,   8'd5,  8'd5,  1, 0, 0, 8'd3);
        addv(1, 1, 1, 0, 0, 8'd0,   8'd0,  8'd0,  1, 0, 0, 8'd3);
        addv(1, 1, 1, 0, 0, 8'd0,   8'd0,  8'd0,  1, 1, 0, 8'd4);
        addv(1, 1, 0, 0, 0, 8'd0,   8'd0,  8'd0,  1, 0, 1, 8'd5);
        addv(0, 1, 0, 0, 0, 8'd0,   8'd0,  8'd0,  1, 0, 0, 8'd0);

        @(negedge clk);
        foreach (vq[i]) begin
            rst = vq[i].rst; en = vq[i].en; up = vq[i].up; ld = vq[i].ld;
            sat = vq[i].sat; din = vq[i].din; max_val = vq[i].max_val;
            tick();
            chk($sformatf("vec%0d.dout", i),   dout,    vq[i].e_dout);
            chk($sformatf("vec%0d.tc", i),     tc,      vq[i].e_tc);
            chk($sformatf("vec%0d.carry", i),  carry,   vq[i].e_carry);
            chk($sformatf("vec%0d.borrow", i), borrow,  vq[i].e_borrow);
            chk($sformatf("vec%0d.ovf", i),    ovf_cnt, vq[i].e_ovf);
        end

        // Idle with en=0 while up toggles: nothing moves.
        max_val = 8'd255; sat = 1'b0; up = 1'b1;
        do_reset();
        chk("rst.dout", dout, 0);
        chk("rst.ovf", ovf_cnt, 0);
        cnt_c = 0; cnt_b = 0;
        for (int i = 0; i < 100; i++) begin
            up = i[0];
            tick();
            if (carry) cnt_c++;
            if (borrow) cnt_b++;
            if (dout != 8'd0) cnt_c += 100;
        end
        chk("idle.dout_pulses", cnt_c + cnt_b, 0);

        // Legacy 8-bit wrap.
        up = 1'b1; en = 1'b1;
        run(255);
        chk("legacy.dout_ff", dout, 255);
        chk("legacy.tc", tc, 1);
        tick();
        chk("legacy.wrap_dout", dout, 0);
        chk("legacy.carry", carry, 1);
        chk("legacy.ovf1", ovf_cnt, 1);
        tick();
        chk("legacy.carry_one_cycle", carry, 0);
        up = 1'b0;
        tick();  // 1 -> 0
        tick();  // 0 -> FF, borrow
        chk("legacy.down_dout", dout, 255);
        chk("legacy.borrow", borrow, 1);
        chk("legacy.ovf2", ovf_cnt, 2);

        // Modulus 100.
        max_val = 8'd99; up = 1'b1;
        do_reset();
        en = 1'b1; cnt_c = 0; cnt_b = 0;
        run(156);
        chk("mod100.up_dout", dout, 56);
        chk("mod100.carries", cnt_c, 1);
        up = 1'b0; cnt_c = 0;
        run(75);
        chk("mod100.down_dout", dout, 81);
        chk("mod100.borrows", cnt_b, 1);
        chk("mod100.ovf", ovf_cnt, 2);

        // Saturate.
        sat = 1'b1; up = 1'b1;
        do_reset();
        en = 1'b1; cnt_c = 0; cnt_b = 0;
        run(200);
        chk("sat.up_dout", dout, 99);
        chk("sat.tc", tc, 1);
        chk("sat.no_carry", cnt_c, 0);
        up = 1'b0;
        run(120);
        chk("sat.down_dout", dout, 0);
        chk("sat.no_borrow", cnt_b, 0);
        chk("sat.ovf", ovf_cnt, 0);

        // Lowering the limit below the current count.
        sat = 1'b0; max_val = 8'd200; din = 8'd150; ld = 1'b1; en = 1'b0;
        tick();
        ld = 1'b0;
        chk("range.load150", dout, 150);
        max_val = 8'd50; en = 1'b1; up = 1'b1;
        tick();
        chk("range.clamp", dout, 50);
        chk("range.no_pulse", carry | borrow, 0);

        // Reset in the middle of counting.
        max_val = 8'd255; up = 1'b1;
        do_reset();
        en = 1'b1;
        run(156);
        chk("midrst.pre", dout, 156);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst.dout", dout, 0);
        chk("midrst.pulses", carry | borrow, 0);
        chk("midrst.ovf", ovf_cnt, 0);

        // Overflow counter saturation with max_val = 0.
        max_val = 8'd0; sat = 1'b0; en = 1'b1; up = 1'b1;
        run(300);
        chk("ovfsat.val", ovf_cnt, 255);
        chk("ovfsat.dout", dout, 0);
        run(5);
        chk("ovfsat.hold", ovf_cnt, 255);
        chk("ovfsat.carry_still", carry, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
